// File: rtl/ppg_window_stats.sv
// ppg_window_stats: windowed min/max/mean of RED and IR samples
// taken from the LED-switching controller's phase transitions.
module ppg_window_stats #(
  parameter int WIN_LOG2 = 5,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              Enable,
  input  logic              LED_RED,
  input  logic              LED_IR,
  input  logic [DATA_W-1:0] RED_ADC_Value,
  input  logic [DATA_W-1:0] IR_ADC_Value,
  output logic [DATA_W-1:0] RED_AC,
  output logic [DATA_W-1:0] RED_DC,
  output logic [DATA_W-1:0] IR_AC,
  output logic [DATA_W-1:0] IR_DC,
  output logic              Stats_Valid,
  output logic              Seq_Err
);

  localparam int SUM_W = DATA_W + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_PAIR =
    CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [DATA_W-1:0] MIN_INIT = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RED,
    ACCUM,
    REPORT
  } state_t;

  state_t state_q, state_d;

  logic              led_red_q;
  logic              exp_ir_q;
  logic              red_stb, ir_stb;
  logic              acc_red, acc_ir;
  logic              clr, report, err;
  logic [CNT_W-1:0]  pair_cnt_q;
  logic [DATA_W-1:0] red_min_q, red_max_q;
  logic [DATA_W-1:0] ir_min_q, ir_max_q;
  logic [SUM_W-1:0]  red_sum_q, ir_sum_q;

  // RED strobe: RED phase just ended; IR strobe: IR phase just ended
  assign red_stb = led_red_q & ~LED_RED & LED_IR;
  assign ir_stb  = ~led_red_q & LED_RED & ~LED_IR;

  // State register
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; Enable low overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (Enable) state_d = WAIT_RED;
      WAIT_RED: if (red_stb) state_d = ACCUM;
      ACCUM: begin
        if (err)
          state_d = WAIT_RED;
        else if (acc_ir && pair_cnt_q == LAST_PAIR)
          state_d = REPORT;
      end
      REPORT:   state_d = WAIT_RED;
      default:  state_d = IDLE;
    endcase
    if (!Enable) state_d = IDLE;
  end

  // Control decode: which strobe is taken, error, clear, report
  always_comb begin
    acc_red = 1'b0;
    acc_ir  = 1'b0;
    err     = 1'b0;
    report  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE:     clr = 1'b1;
      WAIT_RED: acc_red = red_stb;
      ACCUM: begin
        acc_red = red_stb & ~exp_ir_q;
        acc_ir  = ir_stb & exp_ir_q;
        err     = (red_stb & exp_ir_q) |
                  (ir_stb & ~exp_ir_q);
      end
      REPORT: begin
        report = 1'b1;
        clr    = 1'b1;
      end
      default:  clr = 1'b1;
    endcase
    if (!Enable) begin
      acc_red = 1'b0;
      acc_ir  = 1'b0;
      err     = 1'b0;
      clr     = 1'b1;
    end
    if (err) clr = 1'b1;
  end

  // Accumulators, result registers and output pulses
  always_ff @(posedge CLK) begin
    if (rst) begin
      led_red_q   <= 1'b0;
      exp_ir_q    <= 1'b0;
      pair_cnt_q  <= '0;
      red_min_q   <= MIN_INIT;
      red_max_q   <= '0;
      red_sum_q   <= '0;
      ir_min_q    <= MIN_INIT;
      ir_max_q    <= '0;
      ir_sum_q    <= '0;
      RED_AC      <= '0;
      RED_DC      <= '0;
      IR_AC       <= '0;
      IR_DC       <= '0;
      Stats_Valid <= 1'b0;
      Seq_Err     <= 1'b0;
    end else begin
      led_red_q   <= LED_RED;
      Stats_Valid <= report;
      Seq_Err     <= err;
      if (report) begin
        RED_AC <= red_max_q - red_min_q;
        RED_DC <= DATA_W'(red_sum_q >> WIN_LOG2);
        IR_AC  <= ir_max_q - ir_min_q;
        IR_DC  <= DATA_W'(ir_sum_q >> WIN_LOG2);
      end
      if (clr) begin
        exp_ir_q   <= 1'b0;
        pair_cnt_q <= '0;
        red_min_q  <= MIN_INIT;
        red_max_q  <= '0;
        red_sum_q  <= '0;
        ir_min_q   <= MIN_INIT;
        ir_max_q   <= '0;
        ir_sum_q   <= '0;
      end else begin
        if (acc_red) begin
          if (RED_ADC_Value < red_min_q)
            red_min_q <= RED_ADC_Value;
          if (RED_ADC_Value > red_max_q)
            red_max_q <= RED_ADC_Value;
          red_sum_q <= red_sum_q + SUM_W'(RED_ADC_Value);
          exp_ir_q  <= 1'b1;
        end
        if (acc_ir) begin
          if (IR_ADC_Value < ir_min_q)
            ir_min_q <= IR_ADC_Value;
          if (IR_ADC_Value > ir_max_q)
            ir_max_q <= IR_ADC_Value;
          ir_sum_q   <= ir_sum_q + SUM_W'(IR_ADC_Value);
          pair_cnt_q <= pair_cnt_q + CNT_W'(1);
          exp_ir_q   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppg_window_stats.sv
// tb_ppg_window_stats: scoreboard bench for ppg_window_stats,
// one instance with 4-pair windows and one with 256-pair windows.
module tb_ppg_window_stats;

  localparam int PH = 10;

  typedef struct {
    logic [7:0] rac;
    logic [7:0] rdc;
    logic [7:0] iac;
    logic [7:0] idc;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       en2 = 1'b0;
  logic       en8 = 1'b0;
  logic       LED_RED = 1'b0;
  logic       LED_IR = 1'b0;
  logic [7:0] RED_ADC = 8'd0;
  logic [7:0] IR_ADC = 8'd0;

  logic [7:0] rac2, rdc2, iac2, idc2;
  logic [7:0] rac8, rdc8, iac8, idc8;
  logic       sv2, se2, sv8, se8;

  exp_t q2[$];
  exp_t q8[$];
  exp_t pexp;
  int   psel = 2;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   se2_cnt = 0;
  int   se8_cnt = 0;

  ppg_window_stats #(.WIN_LOG2(2), .DATA_W(8)) dut2 (
    .CLK(CLK), .rst(rst), .Enable(en2),
    .LED_RED(LED_RED), .LED_IR(LED_IR),
    .RED_ADC_Value(RED_ADC), .IR_ADC_Value(IR_ADC),
    .RED_AC(rac2), .RED_DC(rdc2),
    .IR_AC(iac2), .IR_DC(idc2),
    .Stats_Valid(sv2), .Seq_Err(se2)
  );

  ppg_window_stats #(.WIN_LOG2(8), .DATA_W(8)) dut8 (
    .CLK(CLK), .rst(rst), .Enable(en8),
    .LED_RED(LED_RED), .LED_IR(LED_IR),
    .RED_ADC_Value(RED_ADC), .IR_ADC_Value(IR_ADC),
    .RED_AC(rac8), .RED_DC(rdc8),
    .IR_AC(iac8), .IR_DC(idc8),
    .Stats_Valid(sv8), .Seq_Err(se8)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] sr(input int m, input int i);
    logic [7:0] a[4];
    case (m)
      0: a = '{8'd100, 8'd120, 8'd140, 8'd110};
      1: a = '{8'd50, 8'd60, 8'd70, 8'd80};
      2: a = '{8'd30, 8'd90, 8'd60, 8'd45};
      4: a = '{8'd1, 8'd2, 8'd3, 8'd4};
      default: return 8'd255;
    endcase
    return a[i];
  endfunction

  function automatic logic [7:0] si(input int m, input int i);
    logic [7:0] a[4];
    case (m)
      0: a = '{8'd200, 8'd180, 8'd220, 8'd190};
      1: a = '{8'd10, 8'd30, 8'd20, 8'd40};
      2: a = '{8'd0, 8'd15, 8'd5, 8'd20};
      4: a = '{8'd9, 8'd9, 8'd9, 8'd9};
      default: return (i % 2 != 0) ? 8'd255 : 8'd0;
    endcase
    return a[i];
  endfunction

  // one clock step: sample at the falling edge, pop scoreboard
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if (se2) se2_cnt++;
    if (se8) se8_cnt++;
    if (sv2) begin
      n_chk++;
      if (q2.size() == 0)
        $display("FAIL report2_unexpected cyc %0d got pulse want none",
                 cyc);
      else begin
        e = q2.pop_front();
        if (rac2 !== e.rac || rdc2 !== e.rdc ||
            iac2 !== e.iac || idc2 !== e.idc || cyc != e.cyc)
          $display("FAIL report2 got %0d/%0d/%0d/%0d @%0d want %0d/%0d/%0d/%0d @%0d",
                   rac2, rdc2, iac2, idc2, cyc,
                   e.rac, e.rdc, e.iac, e.idc, e.cyc);
        else n_pass++;
      end
    end
    if (sv8) begin
      n_chk++;
      if (q8.size() == 0)
        $display("FAIL report8_unexpected cyc %0d got pulse want none",
                 cyc);
      else begin
        e = q8.pop_front();
        if (rac8 !== e.rac || rdc8 !== e.rdc ||
            iac8 !== e.iac || idc8 !== e.idc || cyc != e.cyc)
          $display("FAIL report8 got %0d/%0d/%0d/%0d @%0d want %0d/%0d/%0d/%0d @%0d",
                   rac8, rdc8, iac8, idc8, cyc,
                   e.rac, e.rdc, e.iac, e.idc, e.cyc);
        else n_pass++;
      end
    end
  endtask

  // RED phase; its first cycle is the IR strobe of the prior pair
  task automatic red_phase(input logic [7:0] v, input bit fin);
    exp_t e;
    tick();
    LED_RED = 1'b1;
    LED_IR  = 1'b0;
    RED_ADC = v;
    if (fin) begin
      e = pexp;
      e.cyc = cyc + 2;
      if (psel == 2) q2.push_back(e);
      else q8.push_back(e);
    end
    repeat (PH - 1) tick();
  endtask

  // IR phase; its first cycle is the RED strobe
  task automatic ir_phase(input logic [7:0] v);
    tick();
    LED_RED = 1'b0;
    LED_IR  = 1'b1;
    IR_ADC  = v;
    repeat (PH - 1) tick();
  endtask

  task automatic leds_off(input int n);
    tick();
    LED_RED = 1'b0;
    LED_IR  = 1'b0;
    repeat (n - 1) tick();
  endtask

  task automatic run_pairs(input int n, input int m, input bit fin);
    for (int i = 0; i < n; i++) begin
      red_phase(sr(m, i), 1'b0);
      ir_phase(si(m, i));
    end
    if (fin) red_phase(8'd0, 1'b1);
  endtask

  task automatic check_q2(input string name);
    n_chk++;
    if (q2.size() != 0)
      $display("FAIL %s missing report2 got %0d pending want 0",
               name, q2.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({rac2, rdc2, iac2, idc2, rac8, rdc8, iac8, idc8,
         sv2, se2, sv8, se8} !== 68'd0)
      $display("FAIL reset_outputs got %h want 0",
               {rac2, rdc2, iac2, idc2, rac8, rdc8, iac8, idc8,
                sv2, se2, sv8, se8});
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 20) rst = 1'b0;
      LED_RED = ((i / 5) % 2) != 0;
      LED_IR  = ~LED_RED;
      RED_ADC = 8'($urandom);
      IR_ADC  = 8'($urandom);
    end
    tick();
    n_chk++;
    if ({rac2, rdc2, iac2, idc2, rac8, rdc8, iac8, idc8,
         sv2, se2, sv8, se8} !== 68'd0)
      $display("FAIL idle_outputs got %h want 0",
               {rac2, rdc2, iac2, idc2, rac8, rdc8, iac8, idc8,
                sv2, se2, sv8, se8});
    else n_pass++;
    n_chk++;
    if (se2_cnt + se8_cnt != 0)
      $display("FAIL idle_seq_err got %0d want 0", se2_cnt + se8_cnt);
    else n_pass++;
    leds_off(3);
  endtask

  task automatic test_nominal();
    en2 = 1'b1;
    repeat (2) tick();
    psel = 2;
    pexp = '{rac: 8'd40, rdc: 8'd117, iac: 8'd40, idc: 8'd197, cyc: 0};
    run_pairs(4, 0, 1'b1);
    leds_off(5);
    en2 = 1'b0;
    repeat (3) tick();
    check_q2("nominal");
    n_chk++;
    if ({rac2, rdc2, iac2, idc2} !== {8'd40, 8'd117, 8'd40, 8'd197})
      $display("FAIL nominal_hold got %0d/%0d/%0d/%0d want 40/117/40/197",
               rac2, rdc2, iac2, idc2);
    else n_pass++;
    n_chk++;
    if (se2_cnt != 0)
      $display("FAIL nominal_seq_err got %0d want 0", se2_cnt);
    else n_pass++;
  endtask

  task automatic test_alignment();
    int se0;
    se0 = se2_cnt;
    tick();
    LED_RED = 1'b0;
    LED_IR  = 1'b1;
    IR_ADC  = 8'd250;
    repeat (2) tick();
    en2 = 1'b1;
    repeat (7) tick();
    pexp = '{rac: 8'd30, rdc: 8'd65, iac: 8'd30, idc: 8'd25, cyc: 0};
    run_pairs(4, 1, 1'b1);
    leds_off(5);
    en2 = 1'b0;
    tick();
    check_q2("alignment");
    n_chk++;
    if (se2_cnt != se0)
      $display("FAIL align_seq_err got %0d want %0d", se2_cnt, se0);
    else n_pass++;
  endtask

  task automatic test_seq_err();
    int se0;
    en2 = 1'b1;
    repeat (2) tick();
    red_phase(8'd200, 1'b0);
    ir_phase(8'd250);
    red_phase(8'd210, 1'b0);
    tick();
    LED_RED = 1'b0;
    LED_IR  = 1'b1;
    IR_ADC  = 8'd245;
    repeat (3) tick();
    se0 = se2_cnt;
    LED_RED = 1'b1;
    RED_ADC = 8'd5;
    tick();
    LED_RED = 1'b0;
    tick();
    n_chk++;
    if (se2 !== 1'b1)
      $display("FAIL seq_err_pulse got %b want 1", se2);
    else n_pass++;
    tick();
    n_chk++;
    if (se2 !== 1'b0)
      $display("FAIL seq_err_width got %b want 0", se2);
    else n_pass++;
    n_chk++;
    if (se2_cnt != se0 + 1)
      $display("FAIL seq_err_count got %0d want %0d", se2_cnt, se0 + 1);
    else n_pass++;
    repeat (4) tick();
    pexp = '{rac: 8'd60, rdc: 8'd56, iac: 8'd20, idc: 8'd10, cyc: 0};
    run_pairs(4, 2, 1'b1);
    leds_off(5);
    check_q2("seq_err");
  endtask

  task automatic test_interrupt();
    int se0;
    se0 = se2_cnt;
    red_phase(8'd10, 1'b0);
    ir_phase(8'd30);
    red_phase(8'd20, 1'b0);
    ir_phase(8'd40);
    tick();
    en2 = 1'b0;
    tick();
    en2 = 1'b1;
    tick();
    n_chk++;
    if ({rac2, rdc2, iac2, idc2} !== {8'd60, 8'd56, 8'd20, 8'd10})
      $display("FAIL interrupt_hold got %0d/%0d/%0d/%0d want 60/56/20/10",
               rac2, rdc2, iac2, idc2);
    else n_pass++;
    pexp = '{rac: 8'd3, rdc: 8'd2, iac: 8'd0, idc: 8'd9, cyc: 0};
    run_pairs(4, 4, 1'b1);
    leds_off(5);
    check_q2("interrupt");
    n_chk++;
    if (se2_cnt != se0)
      $display("FAIL interrupt_seq_err got %0d want %0d", se2_cnt, se0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_pairs(2, 0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_chk++;
    if ({rac2, rdc2, iac2, idc2, sv2, se2} !== 34'd0)
      $display("FAIL reset_mid got %0d/%0d/%0d/%0d want 0/0/0/0",
               rac2, rdc2, iac2, idc2);
    else n_pass++;
    repeat (2) tick();
    pexp = '{rac: 8'd40, rdc: 8'd117, iac: 8'd40, idc: 8'd197, cyc: 0};
    run_pairs(4, 0, 1'b1);
    leds_off(5);
    en2 = 1'b0;
    tick();
    check_q2("reset_mid");
  endtask

  task automatic test_extremes();
    en8 = 1'b1;
    repeat (2) tick();
    psel = 8;
    pexp = '{rac: 8'd0, rdc: 8'd255, iac: 8'd255, idc: 8'd127, cyc: 0};
    run_pairs(256, 3, 1'b1);
    leds_off(5);
    en8 = 1'b0;
    tick();
    n_chk++;
    if (q8.size() != 0)
      $display("FAIL extremes missing report8 got %0d pending want 0",
               q8.size());
    else n_pass++;
    n_chk++;
    if (se8_cnt != 0)
      $display("FAIL extremes_seq_err got %0d want 0", se8_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_alignment();
    test_seq_err();
    test_interrupt();
    test_reset_mid();
    test_extremes();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
